// File: rtl/z80_bus_mem.sv
// z80_bus_mem
//   Memory and I/O responder for the tv80s bus. It decodes the CPU strobes,
//   serves reads from separate memory and I/O byte arrays, and inserts a
//   per-cycle-type number of wait states. Every committed bus write updates
//   the selected array and is logged into a trace FIFO.
//
// Ports
//   clk, reset            : CPU clock; synchronous active-high reset
//   m1_n..rfsh_n, A, dout : tv80s bus strobes, address and write data
//   di                    : registered read data back to the CPU
//   wait_n                : wait request to the CPU (low while waiting)
//   ld_en/ld_io/ld_addr/ld_data : backdoor preload, one byte per clock
//   trc_valid/trc_ready   : trace FIFO head handshake
//   trc_data              : {is_io, addr[15:0], data[7:0]} of the head entry
//   trc_ovf               : sticky flag, set when a push finds the FIFO full
//   dbg_state             : current bus FSM state (0 idle, 1 wait, 2 active)
//
// Trace handshake: the head entry is transferred on every rising clk edge
// where trc_valid and trc_ready are both 1; trc_valid never drops without a
// pop, and trc_data holds steady while trc_valid is 1 and trc_ready is 0.
module z80_bus_mem #(
    parameter int         ADDR_W     = 16,
    parameter int         IO_ADDR_W  = 8,
    parameter int         MEM_WS     = 0,
    parameter int         IO_WS      = 1,
    parameter int         M1_WS      = 0,
    parameter int         TRC_DEPTH  = 16,
    parameter logic [7:0] INTACK_VEC = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    output logic        wait_n,
    input  logic        ld_en,
    input  logic        ld_io,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [24:0] trc_data,
    output logic        trc_ovf,
    output logic [1:0]  dbg_state
);

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int IO_DEPTH  = 1 << IO_ADDR_W;
    localparam int PTR_W     = $clog2(TRC_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    logic [7:0]  mem_arr [MEM_DEPTH];
    logic [7:0]  io_arr  [IO_DEPTH];
    logic [24:0] trc_arr [TRC_DEPTH];

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           committed_q, committed_d;
    logic           mem_prev_q, mem_prev_d;
    logic           io_prev_q, io_prev_d;
    logic [7:0]     di_q, di_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           ovf_q, ovf_d;

    logic           mem_sel_n;
    logic           mem_start;
    logic           io_start;
    logic           cyc_start;
    logic [3:0]     ws_sel;
    logic           commit;
    logic           commit_io;
    logic [PTR_W:0] fill;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push_ok;
    logic           unused_sig;

    // rd_n is not needed: di is refreshed every clock regardless of direction.
    assign unused_sig = ^{rd_n, ld_addr};

    // Cycle start detection. A refresh keeps mem_sel_n low, so rfsh_n is
    // also required high; an interrupt acknowledge (m1_n low with iorq_n)
    // never starts a waited cycle.
    always_comb begin
        mem_sel_n  = mreq_n & rfsh_n;
        mem_prev_d = mem_sel_n;
        io_prev_d  = iorq_n;
        mem_start  = mem_prev_q & ~mem_sel_n & rfsh_n;
        io_start   = io_prev_q & ~iorq_n & m1_n;
        cyc_start  = mem_start | io_start;

        if (!m1_n && !mreq_n) begin
            ws_sel = 4'(M1_WS);
        end else if (!mreq_n) begin
            ws_sel = 4'(MEM_WS);
        end else begin
            ws_sel = 4'(IO_WS);
        end
    end

    // Bus FSM. A start is also honoured from ACTIVE so that a new cycle that
    // follows a refresh without both strobes ever being sampled high is not
    // missed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (cyc_start) begin
                    if (ws_sel != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = ws_sel;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (state_q == ST_ACTIVE && mreq_n && iorq_n) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write commit: only once the wait states have elapsed (ACTIVE), so a
    // reset during the waits drops the write. The committed flag keeps a
    // long ACTIVE phase from writing twice.
    always_comb begin
        commit = (state_q == ST_ACTIVE) && !cyc_start && !committed_q &&
                 !wr_n && (!mreq_n || !iorq_n);
        commit_io = !iorq_n;

        if (commit) begin
            committed_d = 1'b1;
        end else if (state_q == ST_IDLE || cyc_start) begin
            committed_d = 1'b0;
        end else begin
            committed_d = committed_q;
        end
    end

    // Trace FIFO bookkeeping. Pointers carry one extra bit so full and empty
    // are distinguishable.
    always_comb begin
        fill       = wr_ptr_q - rd_ptr_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (fill == (PTR_W + 1)'(TRC_DEPTH));
        pop        = !fifo_empty && trc_ready;
        push_ok    = commit && (!fifo_full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d      = ovf_q | (commit && fifo_full && !pop);
    end

    // Read data source, registered every clock.
    always_comb begin
        if (!m1_n && !iorq_n) begin
            di_d = INTACK_VEC;
        end else if (!iorq_n) begin
            di_d = io_arr[A[IO_ADDR_W-1:0]];
        end else begin
            di_d = mem_arr[A[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            committed_q <= 1'b0;
            mem_prev_q  <= 1'b1;
            io_prev_q   <= 1'b1;
            di_q        <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            mem_prev_q  <= mem_prev_d;
            io_prev_q   <= io_prev_d;
            di_q        <= di_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    // Array storage is not reset. The bus commit is written after the
    // preload so that it wins when both hit the same byte.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            if (ld_io) begin
                io_arr[ld_addr[IO_ADDR_W-1:0]] <= ld_data;
            end else begin
                mem_arr[ld_addr[ADDR_W-1:0]] <= ld_data;
            end
        end
        if (commit) begin
            if (commit_io) begin
                io_arr[A[IO_ADDR_W-1:0]] <= dout;
            end else begin
                mem_arr[A[ADDR_W-1:0]] <= dout;
            end
        end
        if (push_ok) begin
            trc_arr[wr_ptr_q[PTR_W-1:0]] <= {commit_io, A, dout};
        end
    end

    assign di        = di_q;
    assign wait_n    = (state_q != ST_WAIT);
    assign trc_valid = !fifo_empty;
    assign trc_data  = fifo_empty ? 25'd0 : trc_arr[rd_ptr_q[PTR_W-1:0]];
    assign trc_ovf   = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_z80_bus_mem.sv
// Directed bench for z80_bus_mem. The main instance runs with MEM_WS=2,
// M1_WS=1, IO_WS=3 and a 4-entry trace FIFO; a second zero-wait instance
// shares the same bus inputs.
module tb_z80_bus_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] a_bus;
  logic [7:0]  dout;
  logic        ld_en, ld_io;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        trc_ready;

  logic [7:0]  di;
  logic        wait_n;
  logic        trc_valid;
  logic [24:0] trc_data;
  logic        trc_ovf;
  logic [1:0]  dbg_state;

  logic [7:0]  z_di;
  logic        z_wait_n;
  logic        z_trc_valid;
  logic [24:0] z_trc_data;
  logic        z_trc_ovf;
  logic [1:0]  z_dbg_state;

  int total = 0;
  int bad = 0;
  int z_wait_low = 0;

  always #5 clk = ~clk;

  z80_bus_mem #(
    .MEM_WS(2), .IO_WS(3), .M1_WS(1), .TRC_DEPTH(4)
  ) u_dut (
    .clk(clk), .reset(reset),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(a_bus), .dout(dout), .di(di), .wait_n(wait_n),
    .ld_en(ld_en), .ld_io(ld_io), .ld_addr(ld_addr), .ld_data(ld_data),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_data(trc_data), .trc_ovf(trc_ovf),
    .dbg_state(dbg_state)
  );

  z80_bus_mem #(
    .MEM_WS(0), .IO_WS(0), .M1_WS(0), .TRC_DEPTH(4)
  ) u_zero (
    .clk(clk), .reset(reset),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(a_bus), .dout(dout), .di(z_di), .wait_n(z_wait_n),
    .ld_en(ld_en), .ld_io(ld_io), .ld_addr(ld_addr), .ld_data(ld_data),
    .trc_valid(z_trc_valid), .trc_ready(trc_ready), .trc_data(z_trc_data), .trc_ovf(z_trc_ovf),
    .dbg_state(z_dbg_state)
  );

  // The zero-wait instance must never request a wait.
  always @(posedge clk) begin
    if (!reset && z_wait_n !== 1'b1) z_wait_low <= z_wait_low + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_release();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic preload(input logic io, input logic [15:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_io = io; ld_addr = addr; ld_data = data;
    step();
    ld_en = 1'b0;
  endtask

  // Drives one complete bus cycle. lows counts wait_n-low clocks (capped at
  // 20); rdata is di sampled once the cycle has completed its waits.
  task automatic bus_cycle(input logic is_io, input logic is_wr, input logic m1,
                           input logic [15:0] addr, input logic [7:0] data,
                           input logic collide, output int lows, output logic [7:0] rdata);
    a_bus = addr; dout = data; m1_n = ~m1;
    if (is_io) iorq_n = 1'b0; else mreq_n = 1'b0;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wait_n === 1'b0) lows++;
      else break;
    end
    if (collide) begin
      ld_en = 1'b1; ld_io = is_io; ld_addr = addr; ld_data = ~data;
    end
    step();
    ld_en = 1'b0;
    rdata = di;
    bus_release();
    step();
  endtask

  task automatic pop_one();
    trc_ready = 1'b1;
    step();
    trc_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (di !== 8'h00) begin bad++; $display("FAIL reset_di: got %h want 00", di); end
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL reset_wait_n: got %b want 1", wait_n); end
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL reset_trc_valid: got %b want 0", trc_valid); end
    total++; if (trc_data !== 25'd0) begin bad++; $display("FAIL reset_trc_data: got %h want 0", trc_data); end
    total++; if (trc_ovf !== 1'b0) begin bad++; $display("FAIL reset_trc_ovf: got %b want 0", trc_ovf); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    int lows;
    logic [7:0] rd;
    preload(1'b0, 16'h0000, 8'hF3);
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, lows, rd);
    total++; if (z_di !== 8'hF3) begin bad++; $display("FAIL zero_fetch_di: got %h want f3", z_di); end
    total++; if (rd !== 8'hF3) begin bad++; $display("FAIL fetch_di: got %h want f3", rd); end
    total++; if (lows !== 1) begin bad++; $display("FAIL fetch_waits: got %0d want 1", lows); end
    total++; if (z_trc_valid !== 1'b0) begin bad++; $display("FAIL zero_fifo_empty: got %b want 0", z_trc_valid); end
  endtask

  // LD A,55h ; LD (8000h),A ; HALT placed at 0x0020.
  task automatic test_program();
    logic        t_wr   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_m1   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] t_addr [7] = '{16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h8000, 16'h0025};
    logic [7:0]  t_data [7] = '{8'h3E, 8'h55, 8'h32, 8'h00, 8'h80, 8'h55, 8'h76};
    int          t_lows [7] = '{1, 2, 1, 2, 2, 2, 1};
    int lows;
    int rlows;
    logic [7:0] rd;
    for (int i = 0; i < 7; i++) begin
      if (!t_wr[i]) preload(1'b0, t_addr[i], t_data[i]);
    end
    for (int i = 0; i < 7; i++) begin
      bus_cycle(1'b0, t_wr[i], t_m1[i], t_addr[i], t_data[i], 1'b0, lows, rd);
      total++; if (lows !== t_lows[i]) begin bad++; $display("FAIL prog_waits[%0d]: got %0d want %0d", i, lows, t_lows[i]); end
      if (!t_wr[i]) begin
        total++; if (rd !== t_data[i]) begin bad++; $display("FAIL prog_di[%0d]: got %h want %h", i, rd, t_data[i]); end
      end
    end
    // A refresh cycle after HALT fetch must not wait.
    mreq_n = 1'b0; rfsh_n = 1'b0; a_bus = 16'h0007;
    rlows = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wait_n !== 1'b1) rlows++;
    end
    bus_release();
    step();
    total++; if (rlows !== 0) begin bad++; $display("FAIL refresh_waits: got %0d want 0", rlows); end
    total++; if (trc_valid !== 1'b1) begin bad++; $display("FAIL prog_trc_valid: got %b want 1", trc_valid); end
    total++; if (trc_data !== {1'b0, 16'h8000, 8'h55}) begin bad++; $display("FAIL prog_trc_data: got %h want %h", trc_data, {1'b0, 16'h8000, 8'h55}); end
    pop_one();
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL prog_single_entry: got %b want 0", trc_valid); end
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b0, lows, rd);
    total++; if (rd !== 8'h55) begin bad++; $display("FAIL prog_mem8000: got %h want 55", rd); end
  endtask

  // LD A,3Ch ; OUT (12h),A placed at 0x0030.
  task automatic test_io();
    int lows;
    logic [7:0] rd;
    preload(1'b0, 16'h0030, 8'h3E);
    preload(1'b0, 16'h0031, 8'h3C);
    preload(1'b0, 16'h0032, 8'hD3);
    preload(1'b0, 16'h0033, 8'h12);
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h0030, 8'h00, 1'b0, lows, rd);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h0031, 8'h00, 1'b0, lows, rd);
    total++; if (rd !== 8'h3C) begin bad++; $display("FAIL io_prog_di: got %h want 3c", rd); end
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h0032, 8'h00, 1'b0, lows, rd);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h0033, 8'h00, 1'b0, lows, rd);
    bus_cycle(1'b1, 1'b1, 1'b0, 16'h0012, 8'h3C, 1'b0, lows, rd);
    total++; if (lows !== 3) begin bad++; $display("FAIL io_write_waits: got %0d want 3", lows); end
    total++; if (trc_data !== {1'b1, 16'h0012, 8'h3C}) begin bad++; $display("FAIL io_trc_data: got %h want %h", trc_data, {1'b1, 16'h0012, 8'h3C}); end
    pop_one();
    bus_cycle(1'b1, 1'b0, 1'b0, 16'h0012, 8'h00, 1'b0, lows, rd);
    total++; if (lows !== 3) begin bad++; $display("FAIL io_read_waits: got %0d want 3", lows); end
    total++; if (rd !== 8'h3C) begin bad++; $display("FAIL io_read_di: got %h want 3c", rd); end
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL io_read_no_trace: got %b want 0", trc_valid); end
  endtask

  task automatic test_overflow();
    int lows;
    logic [7:0] rd;
    logic [24:0] exp;
    trc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_cycle(1'b0, 1'b1, 1'b0, 16'h9000 + 16'(i), 8'hA0 + 8'(i), 1'b0, lows, rd);
    end
    total++; if (trc_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", trc_ovf); end
    for (int i = 0; i < 4; i++) begin
      exp = {1'b0, 16'h9000 + 16'(i), 8'hA0 + 8'(i)};
      total++; if (trc_data !== exp) begin bad++; $display("FAIL ovf_entry[%0d]: got %h want %h", i, trc_data, exp); end
      pop_one();
    end
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", trc_valid); end
    total++; if (trc_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", trc_ovf); end
    pop_one();
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL pop_empty: got %b want 0", trc_valid); end
    total++; if (trc_data !== 25'd0) begin bad++; $display("FAIL pop_empty_data: got %h want 0", trc_data); end
  endtask

  task automatic test_collision();
    int lows;
    logic [7:0] rd;
    bus_cycle(1'b0, 1'b1, 1'b0, 16'hA000, 8'h77, 1'b1, lows, rd);
    total++; if (trc_data !== {1'b0, 16'hA000, 8'h77}) begin bad++; $display("FAIL collide_trc: got %h want %h", trc_data, {1'b0, 16'hA000, 8'h77}); end
    pop_one();
    bus_cycle(1'b0, 1'b0, 1'b0, 16'hA000, 8'h00, 1'b0, lows, rd);
    total++; if (rd !== 8'h77) begin bad++; $display("FAIL collide_mem: got %h want 77", rd); end
  endtask

  task automatic test_reset_mid();
    int lows;
    logic [7:0] rd;
    preload(1'b0, 16'hB000, 8'h42);
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL preload_no_trace: got %b want 0", trc_valid); end
    a_bus = 16'hB000; dout = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
    step();
    step();
    total++; if (wait_n !== 1'b0) begin bad++; $display("FAIL mid_second_wait: got %b want 0", wait_n); end
    reset = 1'b1;
    step();
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL mid_reset_wait_n: got %b want 1", wait_n); end
    reset = 1'b0;
    bus_release();
    step();
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_trc: got %b want 0", trc_valid); end
    bus_cycle(1'b0, 1'b0, 1'b0, 16'hB000, 8'h00, 1'b0, lows, rd);
    total++; if (rd !== 8'h42) begin bad++; $display("FAIL mid_reset_byte: got %h want 42", rd); end
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b0, lows, rd);
    total++; if (rd !== 8'h55) begin bad++; $display("FAIL mid_reset_keep: got %h want 55", rd); end
  endtask

  task automatic test_intack();
    int lows;
    a_bus = 16'h0038; m1_n = 1'b0; iorq_n = 1'b0;
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wait_n !== 1'b1) lows++;
    end
    total++; if (di !== 8'hFF) begin bad++; $display("FAIL intack_di: got %h want ff", di); end
    total++; if (lows !== 0) begin bad++; $display("FAIL intack_waits: got %0d want 0", lows); end
    bus_release();
    step();
    step();
    total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL intack_no_trace: got %b want 0", trc_valid); end
  endtask

  initial begin
    reset = 1'b1;
    bus_release();
    a_bus = 16'h0000; dout = 8'h00;
    ld_en = 1'b0; ld_io = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
    trc_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_program();
    test_io();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_intack();
    total++; if (z_wait_low !== 0) begin bad++; $display("FAIL zero_ws_never_low: got %0d want 0", z_wait_low); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_bus_mem.md
# z80_bus_mem

Parametrised memory and I/O responder for the tv80s bus, used by CPU instruction-level benches and small SoC builds. It decodes `mreq_n`/`iorq_n`/`rd_n`/`wr_n` and serves reads from separate memory and I/O arrays. It inserts a configurable number of wait states per cycle type and logs every committed write into a trace FIFO, so a checker can compare bus writes against expected values.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width; memory depth is 2^ADDR_W bytes.
- `IO_ADDR_W`, 8: I/O address width; the low bits of `A` are used.
- `MEM_WS`, 0: wait states added to memory read/write cycles (0..15).
- `IO_WS`, 1: wait states added to I/O read/write cycles (0..15).
- `M1_WS`, 0: wait states added to opcode fetch (`m1_n`=0 with `mreq_n`=0) (0..15).
- `TRC_DEPTH`, 16: trace FIFO entries; must be a power of two, at least 2.
- `INTACK_VEC`, 8'hFF: byte returned during an interrupt acknowledge cycle.

Ports:
- `clk`, in, 1: CPU clock (same net as tv80s `clk`).
- `reset`, in, 1: synchronous, active-high.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n`, in, 1 each: tv80s bus strobes.
- `A`, in, 16: CPU address.
- `dout`, in, 8: CPU write data.
- `di`, out, 8: CPU read data.
- `wait_n`, out, 1: wait request to tv80s.
- `ld_en`, in, 1: backdoor preload strobe, one byte per cycle.
- `ld_io`, in, 1: 1 selects the I/O array, 0 the memory array.
- `ld_addr`, in, 16: preload address.
- `ld_data`, in, 8: preload data.
- `trc_valid`, out, 1: trace entry available.
- `trc_ready`, in, 1: consumer pop.
- `trc_data`, out, 25: {is_io, addr[15:0], data[7:0]} for the head entry.
- `trc_ovf`, out, 1: sticky overflow flag.

## Operation
- Cycle start: falling edge of (`mreq_n` & `rfsh_n`) or of `iorq_n`, detected against the previous-cycle registered value. Refresh cycles (`rfsh_n`=0) and interrupt acknowledge (`m1_n`=0 & `iorq_n`=0) never start a waited cycle.
- Wait count chosen at start: `M1_WS` if `m1_n`=0 & `mreq_n`=0; `MEM_WS` if `mreq_n`=0; `IO_WS` if `iorq_n`=0.
- State machine:
  - IDLE to WAIT on a cycle start with count>0, loading the counter.
  - IDLE to ACTIVE on a cycle start with count=0.
  - WAIT: counter decrements each cycle; goes to ACTIVE when it reaches 1.
  - ACTIVE to IDLE when both `mreq_n` and `iorq_n` are high.
  - Any state to IDLE on `reset`.
- `di` source, registered every cycle:
  - `INTACK_VEC` when `m1_n`=0 & `iorq_n`=0.
  - I/O array at `A[IO_ADDR_W-1:0]` when `iorq_n`=0.
  - Memory array at `A[ADDR_W-1:0]` otherwise.
- Write commit: exactly once per bus cycle, on the first cycle where the strobe is low, `wr_n`=0 and `wait_n`=1. A per-cycle `committed` flag blocks repeats and clears in IDLE. The commit writes the selected array and pushes {is_io, `A`, `dout`} to the trace FIFO.
- Preload: `ld_en` writes immediately and does not trace. If it targets the same array/address as a bus commit in the same cycle, the bus commit wins.
- Trace FIFO:
  - Push when full: the entry is dropped and `trc_ovf` is set until reset.
  - Push and pop in the same cycle when full: both are accepted and `trc_ovf` is unchanged.
  - Pop when empty: ignored.
- Reset clears the FSM, counter, FIFO pointers and `trc_ovf`. Array contents are preserved.

## Timing
- Reset values: `di`=8'h00, `wait_n`=1, `trc_valid`=0, `trc_data`=0, `trc_ovf`=0.
- `di` latency: 1 clock after `A`/strobe changes.
- `wait_n` latency:
  - Goes low the clock after cycle start.
  - Stays low for exactly N clocks, then returns high.
  - With N=0 it never goes low.
- Memory write becomes visible on the clock edge after commit; a read of that address the following cycle returns the new value.
- `trc_valid` rises 1 clock after the commit.
- Pop takes effect on the clock edge where `trc_valid` & `trc_ready` are both 1; the next entry is presented the following cycle.
- Reset asserted mid-cycle: `wait_n` is 1 on the next clock. A write not yet committed is not performed.

## Test plan
- Preload mem[0]=F3 (DI), all waits 0, release reset, run 8 clocks -> PC=0001, IFF1=IFF2=0, `wait_n` never low, FIFO empty.
- `MEM_WS`=2, `M1_WS`=1, program `LD A,55h; LD (8000h),A; HALT` -> each fetch shows 1 low `wait_n` clock and each data cycle 2. mem[8000]=55. FIFO holds a single entry {0,8000,55}.
- `IO_WS`=3, program `LD A,3Ch; OUT (12h),A` -> io[12]=3C, 3 wait clocks on the I/O cycle, trace {1,0012,3C}.
- `TRC_DEPTH`=4, `trc_ready`=0, 5 memory writes -> 4 entries in order, `trc_ovf`=1. Then pop 4 -> `trc_valid`=0, `trc_ovf` stays 1.
- Assert `reset` during the 2nd wait clock of a `MEM_WS`=3 write -> `wait_n`=1 next clock, target byte unchanged, `trc_valid`=0.
- Force an interrupt acknowledge (`m1_n`=0, `iorq_n`=0) -> `di`=FF, no wait states, no trace entry.
